// File: rtl/trivium_uart_decrypt_rx.sv
// Trivium UART receive side: 8N1 (8E1 with TRIVIUM_UART_DECRYPT_RX_PARITY_EN) deserializer,
// one-byte pending stage, keystream XOR and a ready/valid plaintext output register.
module trivium_uart_decrypt_rx #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   input  logic [7:0] ks_byte,
   input  logic       ks_valid,
   output logic       ks_read,
   output logic [7:0] pt_data,
   output logic       pt_valid,
   input  logic       pt_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta, rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       s_cnt;
   logic [3:0]       bit_cnt;
   logic [1:0]       sh;
   logic [7:0]       shreg;
   logic [7:0]       pend;
   logic             pend_full;

   logic tick_c, mid_c, maj_c, stop_mid_c, par_ok_c;
   logic byte_done_c, frame_bad_c, xfer_c;

   // Two-flop synchronizer; idle-high line
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_s    <= rx_meta;
      end
   end

   assign tick_c = (state_q != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and sample decode
   always_comb begin
      state_d     = state_q;
      mid_c       = tick_c && (s_cnt == 4'd8);
      maj_c       = (sh[1] & sh[0]) | (sh[1] & rx_s) | (sh[0] & rx_s);
      stop_mid_c  = (state_q == S_STOP) && mid_c;
      byte_done_c = stop_mid_c && maj_c && par_ok_c;
      frame_bad_c = stop_mid_c && !maj_c;
      case (state_q)
         S_IDLE:  if (!rx_s) state_d = S_START;
         S_START: begin
            if (tick_c && (s_cnt == 4'd7) && rx_s) state_d = S_IDLE;
            else if (tick_c && (s_cnt == 4'd15))   state_d = S_DATA;
         end
         S_DATA: begin
            if (tick_c && (s_cnt == 4'd15) && (bit_cnt == 4'd8)) begin
`ifdef TRIVIUM_UART_DECRYPT_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef TRIVIUM_UART_DECRYPT_RX_PARITY_EN
         S_PARITY: if (tick_c && (s_cnt == 4'd15)) state_d = S_STOP;
`endif
         S_STOP:  if (mid_c) state_d = maj_c ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Baud tick, sample-slot counter and bit shifter; all held clear in IDLE
   always_ff @(posedge clk) begin
      if (rst || (state_q == S_IDLE)) begin
         div_cnt <= '0;
         s_cnt   <= 4'd0;
         bit_cnt <= 4'd0;
         sh      <= 2'b11;
      end else begin
         div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
         if (tick_c) begin
            s_cnt <= s_cnt + 4'd1;
            if ((s_cnt == 4'd6) || (s_cnt == 4'd7)) sh <= {sh[0], rx_s};
            if ((s_cnt == 4'd8) && (state_q == S_DATA)) begin
               shreg   <= {maj_c, shreg[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
      end
   end

`ifdef TRIVIUM_UART_DECRYPT_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk) begin
      if (rst)                                    par_bit <= 1'b0;
      else if ((state_q == S_PARITY) && mid_c)    par_bit <= maj_c;
   end

   assign par_ok_c = (par_bit == ^shreg);

   // Parity mismatch reported at the stop-bit sample
   always_ff @(posedge clk) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= stop_mid_c && !par_ok_c;
   end
`else
   assign par_ok_c   = 1'b1;
   assign parity_err = 1'b0;
`endif

   // Keystream is only consumed when the pending byte can move to the output
   assign xfer_c  = pend_full && ks_valid && (!pt_valid || pt_ready);
   assign ks_read = xfer_c;

   // Pending stage, output register and flag pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 8'h00;
         pend_full <= 1'b0;
         pt_data   <= 8'h00;
         pt_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_bad_c;
         overrun   <= byte_done_c && pend_full;
         if (xfer_c) begin
            pend_full <= 1'b0;
         end else if (byte_done_c && !pend_full) begin
            pend      <= shreg;
            pend_full <= 1'b1;
         end
         if (xfer_c) begin
            pt_data  <= pend ^ ks_byte;
            pt_valid <= 1'b1;
         end else if (pt_valid && pt_ready) begin
            pt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trivium_uart_decrypt_rx.sv
// Directed bench for trivium_uart_decrypt_rx with a byte-level scoreboard model.
module tb_trivium_uart_decrypt_rx;

   localparam int BIT_CLK = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_serial = 1'b1;
   logic [7:0] ks_byte = 8'h00;
   logic       ks_valid = 1'b0;
   logic       pt_ready = 1'b0;
   logic       ks_read, pt_valid, frame_err, parity_err, overrun;
   logic [7:0] pt_data;

   always #5 clk = ~clk;

   trivium_uart_decrypt_rx #(
      .CLK_FREQ  (1600000),
      .BAUD_RATE (10000),
      .OVERSAMPLE(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .ks_byte   (ks_byte),
      .ks_valid  (ks_valid),
      .ks_read   (ks_read),
      .pt_data   (pt_data),
      .pt_valid  (pt_valid),
      .pt_ready  (pt_ready),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .overrun   (overrun)
   );

   int n_tot = 0, n_bad = 0;
   int ks_cnt = 0, acc_cnt = 0, pv_cyc = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
   int exp_ks = 0, exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_pend[$];
   bit         m_out_full = 1'b0;
   logic [7:0] last_pt = 8'h00;
   logic       held_v = 1'b0;
   logic [7:0] held_d = 8'h00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tot++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Byte-level model: where a completed frame goes and what plaintext it must yield
   task automatic model_step();
      if (m_pend.size() != 0 && ks_valid && (!m_out_full || pt_ready)) begin
         exp_q.push_back(m_pend.pop_front() ^ ks_byte);
         exp_ks++;
         m_out_full = !pt_ready;
      end
   endtask

   task automatic model_frame(input logic [7:0] c, input bit stop_ok, input bit par_ok);
      if (!stop_ok) exp_ferr++;
      if (!par_ok)  exp_perr++;
      if (stop_ok && par_ok) begin
         if (m_pend.size() != 0) exp_ovr++;
         else                    m_pend.push_back(c);
      end
      model_step();
   endtask

   task automatic model_release();
      m_out_full = 1'b0;
      model_step();
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx_serial = v;
      wait_clk(BIT_CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TRIVIUM_UART_DECRYPT_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      send_bit(stop);
      rx_serial = 1'b1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_ks_reads"},   ks_cnt,       exp_ks);
      check({tag, "_frame_errs"}, ferr_cnt,     exp_ferr);
      check({tag, "_parity_errs"}, perr_cnt,    exp_perr);
      check({tag, "_overruns"},   ovr_cnt,      exp_ovr);
      check({tag, "_pt_left"},    exp_q.size(), 0);
   endtask

   // Per-cycle compare against the scoreboard and handshake rules
   always @(negedge clk) begin
      if (!rst) begin
         if (ks_read) begin
            ks_cnt++;
            check("ks_read_without_valid", ks_valid, 1'b1);
         end
         if (pt_valid) pv_cyc++;
         if (held_v && pt_valid) check("pt_data_stable", pt_data, held_d);
         held_v = pt_valid && !pt_ready;
         held_d = pt_data;
         if (pt_valid && pt_ready) begin
            acc_cnt++;
            last_pt = pt_data;
            check("pt_was_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("pt_data", pt_data, exp_q.pop_front());
         end
         if (frame_err)  ferr_cnt++;
         if (parity_err) perr_cnt++;
         if (overrun)    ovr_cnt++;
      end
   end

   int ks0, acc0, pv0, fe0, ov0, pe0;

   task automatic snap();
      ks0 = ks_cnt; acc0 = acc_cnt; pv0 = pv_cyc; fe0 = ferr_cnt; ov0 = ovr_cnt; pe0 = perr_cnt;
   endtask

   initial begin
      wait_clk(5);
      check("rst_ks_read",    ks_read,    1'b0);
      check("rst_pt_data",    pt_data,    8'h00);
      check("rst_pt_valid",   pt_valid,   1'b0);
      check("rst_frame_err",  frame_err,  1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_overrun",    overrun,    1'b0);
      rst = 1'b0;
      wait_clk(20);

      // Single byte A5 ^ 3C
      ks_byte = 8'h3C; ks_valid = 1'b1; pt_ready = 1'b1;
      snap();
      model_frame(8'hA5, 1'b1, 1'b1);
      send_frame(8'hA5, 1'b1, 1'b0);
      wait_clk(200);
      check("single_pt",       last_pt,       8'h99);
      check("single_ks_delta", ks_cnt - ks0,  1);
      check("single_pv_cyc",   pv_cyc - pv0,  1);
      check_model("single");

      // Glitch: 40 clk low is rejected at the start-bit mid sample
      snap();
      rx_serial = 1'b0;
      wait_clk(40);
      rx_serial = 1'b1;
      wait_clk(400);
      check("glitch_acc", acc_cnt - acc0, 0);
      check("glitch_ks",  ks_cnt - ks0,   0);
      check("glitch_fe",  ferr_cnt - fe0, 0);
      check_model("glitch");

      // Bad stop bit, line held low, then a good frame
      ks_byte = 8'h01;
      snap();
      model_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'h55, 1'b0, 1'b0);
      rx_serial = 1'b0;
      wait_clk(2 * BIT_CLK);
      rx_serial = 1'b1;
      wait_clk(2 * BIT_CLK);
      check("badstop_fe",      ferr_cnt - fe0, 1);
      check("badstop_no_ks",   ks_cnt - ks0,   0);
      model_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'h01, 1'b1, 1'b0);
      wait_clk(200);
      check("badstop_next_pt", last_pt,      8'h00);
      check("badstop_ks",      ks_cnt - ks0, 1);
      check_model("badstop");

      // Stall and overrun, frames back to back
      ks_byte = 8'h00; pt_ready = 1'b0;
      snap();
      model_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h22, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0);
      model_frame(8'h33, 1'b1, 1'b1);
      send_frame(8'h33, 1'b1, 1'b0);
      wait_clk(50);
      check("stall_pt_valid", pt_valid,      1'b1);
      check("stall_pt_held",  pt_data,       8'h11);
      check("stall_overrun",  ovr_cnt - ov0, 1);
      check("stall_ks_one",   ks_cnt - ks0,  1);
      pt_ready = 1'b1;
      model_release();
      wait_clk(20);
      check("stall_last_pt", last_pt,        8'h22);
      check("stall_ks_two",  ks_cnt - ks0,   2);
      check("stall_acc",     acc_cnt - acc0, 2);
      check_model("stall");

      // Keystream stall
      ks_valid = 1'b0;
      snap();
      model_frame(8'h7E, 1'b1, 1'b1);
      send_frame(8'h7E, 1'b1, 1'b0);
      wait_clk(500);
      check("ksstall_no_ks", ks_cnt - ks0, 0);
      check("ksstall_no_pv", pt_valid,     1'b0);
      ks_byte = 8'hFF; ks_valid = 1'b1;
      model_step();
      wait_clk(20);
      check("ksstall_pt", last_pt,      8'h81);
      check("ksstall_ks", ks_cnt - ks0, 1);
      check_model("ksstall");

      // Reset in the middle of a frame
      snap();
      rx_serial = 1'b0;
      wait_clk(3 * BIT_CLK);
      rst = 1'b1;
      wait_clk(3);
      rx_serial = 1'b1;
      rst = 1'b0;
      wait_clk(2 * BIT_CLK);
      check("midrst_fe",  ferr_cnt - fe0, 0);
      check("midrst_ovr", ovr_cnt - ov0,  0);
      check("midrst_ks",  ks_cnt - ks0,   0);
      check("midrst_pv",  pt_valid,       1'b0);
      check_model("midrst");

`ifdef TRIVIUM_UART_DECRYPT_RX_PARITY_EN
      // Wrong then correct even parity
      ks_byte = 8'h00;
      snap();
      model_frame(8'h03, 1'b1, 1'b0);
      send_frame(8'h03, 1'b1, 1'b1);
      wait_clk(200);
      check("parity_err_cnt", perr_cnt - pe0, 1);
      check("parity_no_pt",   acc_cnt - acc0, 0);
      check("parity_no_ks",   ks_cnt - ks0,   0);
      model_frame(8'h03, 1'b1, 1'b1);
      send_frame(8'h03, 1'b1, 1'b0);
      wait_clk(200);
      check("parity_good_pt", last_pt, 8'h03);
      check_model("parity");
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/trivium_uart_decrypt_rx.md
# trivium_uart_decrypt_rx

Far-end peer of the Trivium encrypting UART bridge. It receives the ciphertext serial stream, deserializes 8N1 frames with 16x oversampling, XORs each good byte with one byte from a local Trivium keystream source, and presents the plaintext on a ready/valid byte interface. It has a one-byte pending stage plus an output register, so a stalled keystream or a stalled consumer does not lose a frame immediately.

## Interface
Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Fixed at 16; other values are unsupported.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_serial  in  1  asynchronous ciphertext line; idles high.
- ks_byte  in  8  keystream byte from the Trivium core.
- ks_valid  in  1  ks_byte is available.
- ks_read  out  1  one-cycle pulse; consumes ks_byte.
- pt_data  out  8  decrypted byte.
- pt_valid  out  1  pt_data is valid; held until accepted.
- pt_ready  in  1  consumer accepts pt_data.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- parity_err  out  1  one-cycle pulse on a parity mismatch; tied 0 unless the parity macro is defined.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer:** rx_serial passes through a 2-FF synchronizer. Both flops reset to 1.
- **Tick generator:** DIV = CLK_FREQ/(BAUD_RATE*16), integer division, DIV ≥ 2. It produces a one-cycle tick every DIV clocks and is free-running only while the FSM is not in IDLE.
- **FSM states:**
  - IDLE → START when the synchronized line is 0. The tick counter clears on entry.
  - START: at tick 8, a line still at 0 goes to DATA; a line at 1 is a glitch and returns to IDLE with no flags raised.
  - DATA: 8 bits, LSB first. Each bit value is the majority of samples at ticks 7, 8 and 9. The bit boundary is 16 ticks.
  - STOP: sampled at tick 8 by majority.
    - Stop = 1: the byte is offered to the pending stage, and the FSM returns to IDLE.
    - Stop = 0: frame_err pulses, the byte is discarded, and the FSM goes to BREAK.
  - BREAK → IDLE once the synchronized line reads 1.
- **Pending stage:** one byte plus a full flag.
  - A completed byte loads into it if it is empty.
  - If it is full, overrun pulses and the new byte is dropped. No keystream is consumed.
- **Cipher transfer** fires when pend_full && ks_valid && (!pt_valid || pt_ready). In that cycle:
  - ks_read = 1 (combinational, same cycle).
  - On the edge, pt_data <= pend ^ ks_byte, pt_valid <= 1, and pend_full <= 0.
- **Output accept:** pt_valid && pt_ready with no simultaneous transfer clears pt_valid. A simultaneous accept and transfer keeps pt_valid at 1 with the new data.
- **Keystream ordering:** exactly one ks_read per delivered byte. Erroneous and dropped bytes never consume keystream, so keystream alignment holds only while the link is error-free. Recovery is a system-level rst.

## Timing
- **Reset values:** ks_read=0, pt_data=8'h00, pt_valid=0, frame_err=0, parity_err=0, overrun=0. FSM in IDLE, pending stage empty.
- **rst mid-frame:** aborts the frame, no flags are raised, and keystream is untouched.
- **Latency:** define cycle S as the stop-sample edge; the pending stage loads on S. If ks_valid=1 and the output is free, ks_read is high in cycle S+1 and pt_valid rises at the S+1 edge. Line-to-sampler delay is 2 clocks from the synchronizer.
- **Handshake rules:**
  - pt_data stays stable while pt_valid && !pt_ready.
  - ks_read is never asserted while ks_valid=0.
- **Flag pulses:** frame_err, parity_err and overrun are each exactly one cycle, on the edge after the offending sample or load attempt.
- **Back-to-back frames:** a start bit immediately after the stop-bit mid-sample is detected, since IDLE is re-entered at the stop-bit mid-point.

## Configuration
- Macro: TRIVIUM_UART_DECRYPT_RX_PARITY_EN.
- **Defined:**
  - The frame is 8E1; an even parity bit follows D7 and is sampled like a data bit in a PARITY state.
  - On a mismatch, parity_err pulses at the stop-bit sample, the byte is discarded, and no keystream is consumed. The frame_err check still applies.
- **Undefined:**
  - The frame is 8N1 with no PARITY state.
  - parity_err is constant 0.

## Test plan
All scenarios use CLK_FREQ=1600000 and BAUD_RATE=10000, giving DIV=10 and 160 clk per bit.
- **Single byte:** ciphertext 8'hA5 sent with ks_byte=8'h3C, ks_valid=1, pt_ready=1 → one ks_read pulse, pt_data=8'h99, pt_valid high 1 cycle, no flags.
- **Glitch:** a 0 on the line for 40 clk, then idle → no pt_valid, no ks_read, no flags, FSM back in IDLE.
- **Bad stop bit:** frame 8'h55 with stop=0, then the line held low for 2 bit times, then frame 8'h01 with ks_byte=8'h01 → frame_err pulses once, no ks_read for the bad frame, second frame gives pt_data=8'h00.
- **Stall and overrun:** pt_ready=0 and ks_valid=1 while sending 8'h11, 8'h22, 8'h33 with ks_byte=0 → pt_data=8'h11 held, 8'h22 pending, overrun pulses on 8'h33. Then pt_ready=1 → 8'h22 delivered, 2 ks_read pulses total.
- **Keystream stall:** ks_valid=0 while 8'h7E arrives, then ks_valid=1 with ks_byte=8'hFF after 500 clk → ks_read and pt_valid in the same transfer, pt_data=8'h81.
- **Parity (macro defined):** 8'h03 sent with parity bit 1 → parity_err pulses once, no pt_valid. Correct parity 0 → normal delivery.
